// File: rtl/dot_feeder_14_pkg.sv
// Shared definitions for the dot_feeder_14 slice.
//   - Element width comes from the `DOT_DATA_LEN macro. Another file may define it
//     first; otherwise it falls back to 16 here.
//   - VEC_W is the width of one 36-element phase slice.
//   - feeder_state_t gives the state encodings IDLE=0, COLLECT=1, RUN=2,
//     WAIT=3 and HOLD=4.
`ifndef DOT_DATA_LEN
`define DOT_DATA_LEN 16
`endif

package dot_feeder_14_pkg;

  localparam int unsigned DATA_LEN    = `DOT_DATA_LEN;
  localparam int unsigned N_ELEM      = 36;
  localparam int unsigned VEC_W       = N_ELEM * DATA_LEN;
  localparam int unsigned N_PHASE_DEF = 6;
  localparam int unsigned WS_LAT_DEF  = 1;
  localparam int unsigned TO_CYC_DEF  = 64;
  localparam int unsigned PH_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_RUN     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLD    = 3'd4
  } feeder_state_t;

  // Advances a phase index by one and stops at last_ph.
  function automatic logic [PH_W-1:0] phase_step(input logic [PH_W-1:0] ph,
                                                 input logic [PH_W-1:0] last_ph);
    return (ph == last_ph) ? ph : ph + 1'b1;
  endfunction

endpackage

// File: rtl/dot_feeder_14_vec_buf.sv
// dot_vec_buf: register file of N_ENT x W bits for the dot_feeder_14 slice buffer.
// The data array has no reset. Stale contents are never read, because the
// feeder only replays a slice after all of its beats have been written.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_idx   in   write entry index
//   wr_data  in   write data
//   rd_idx   in   read entry index (combinational read)
//   rd_data  out  read data
module dot_vec_buf #(
  parameter int unsigned N_ENT = 6,
  parameter int unsigned W     = 576,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [N_ENT];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dot_feeder_14.sv
// dot_feeder_14: upstream driver for one 36-wide dot channel.
//
// Operation:
//   - Collects N_PHASE input slices for one channel select.
//   - Replays the slices phase-aligned with the channel weight store.
//   - Captures the channel result and returns it downstream on a
//     valid/ready handshake.
//
// Optional watchdog (macro DOT_FEEDER_TIMEOUT_EN):
//   - When the macro is defined, a result that has not arrived TO_CYC cycles
//     after RUN entry sets the sticky err flag and releases a zero result.
//   - When the macro is undefined, err is tied to 0.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   in_valid/in_ready         upstream slice handshake
//   in_cs                     channel select, sampled with beat 0 only
//   in_data                   one phase slice (beat k = phase k)
//   dc_load/ws_load           channel accumulate and weight-store enables
//   cs, phase, d              channel select, weight phase, aligned slice
//   dc_valid, dc_q            channel result strobe and value
//   res_valid/res_ready       downstream result handshake
//   res_cs, res_data          captured select and result
//   err                       sticky timeout flag
module dot_feeder_14
  import dot_feeder_14_pkg::*;
#(
  parameter int unsigned N_PHASE = N_PHASE_DEF,
  parameter int unsigned WS_LAT  = WS_LAT_DEF,
  parameter int unsigned TO_CYC  = TO_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_cs,
  input  logic [VEC_W-1:0]    in_data,
  output logic                dc_load,
  output logic                ws_load,
  output logic [3:0]          cs,
  output logic [PH_W-1:0]     phase,
  output logic [VEC_W-1:0]    d,
  input  logic                dc_valid,
  input  logic [DATA_LEN-1:0] dc_q,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [3:0]          res_cs,
  output logic [DATA_LEN-1:0] res_data,
  output logic                err
);

  localparam int unsigned BC_W  = $clog2(N_PHASE + 1);
  localparam int unsigned CNT_W = $clog2(TO_CYC + N_PHASE + WS_LAT + 2);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(N_PHASE - 1);

  feeder_state_t state, state_nxt;

  logic [BC_W-1:0]  beat_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [PH_W-1:0]  ph_pipe [WS_LAT];
  logic [VEC_W-1:0] rd_data;
  logic             accept;
  logic             capture;
  logic             finish;
`ifdef DOT_FEEDER_TIMEOUT_EN
  logic             timeout;
  logic             err_q;
`endif

  assign in_ready = !rst && ((state == ST_IDLE) ||
                             (state == ST_COLLECT && beat_cnt < BC_W'(N_PHASE)));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
`ifdef DOT_FEEDER_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_COLLECT;
      ST_COLLECT: if (accept && beat_cnt == BC_W'(N_PHASE - 1)) state_nxt = ST_RUN;
      ST_RUN:     if (cyc_cnt == CNT_W'(N_PHASE + WS_LAT - 1)) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (dc_valid) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
`ifdef DOT_FEEDER_TIMEOUT_EN
        else if (cyc_cnt == CNT_W'(TO_CYC - 1)) begin
          timeout   = 1'b1;
          state_nxt = ST_HOLD;
        end
`endif
      end
      ST_HOLD:    if (res_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

`ifdef DOT_FEEDER_TIMEOUT_EN
  assign finish = capture || timeout;
`else
  assign finish = capture;
`endif

  // ph_pipe delays the phase by WS_LAT cycles so that the slice read from
  // the buffer meets its weights. The pipe is cleared at RUN entry, which
  // makes d show buf[0] for the first WS_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      cyc_cnt   <= '0;
      phase     <= '0;
      dc_load   <= 1'b0;
      ws_load   <= 1'b0;
      res_valid <= 1'b0;
      res_cs    <= '0;
      res_data  <= '0;
      cs        <= '0;
      for (int unsigned i = 0; i < WS_LAT; i++) ph_pipe[i] <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (state == ST_IDLE) cs <= in_cs;
      end
      case (state)
        ST_COLLECT: begin
          if (state_nxt == ST_RUN) begin
            dc_load <= 1'b1;
            ws_load <= 1'b1;
            phase   <= '0;
            cyc_cnt <= '0;
            for (int unsigned i = 0; i < WS_LAT; i++) ph_pipe[i] <= '0;
          end
        end
        ST_RUN, ST_WAIT: begin
          if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
          phase      <= phase_step(phase, LAST_PH);
          ph_pipe[0] <= phase;
          for (int unsigned i = 1; i < WS_LAT; i++) ph_pipe[i] <= ph_pipe[i-1];
          if (finish) begin
            dc_load   <= 1'b0;
            ws_load   <= 1'b0;
            res_valid <= 1'b1;
            res_cs    <= cs;
            res_data  <= capture ? dc_q : '0;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            beat_cnt  <= '0;
            phase     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DOT_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  dot_vec_buf #(
    .N_ENT (N_PHASE),
    .W     (VEC_W),
    .IDX_W (PH_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_idx  (PH_W'(beat_cnt)),
    .wr_data (in_data),
    .rd_idx  (ph_pipe[WS_LAT-1]),
    .rd_data (rd_data)
  );

  assign d = (state == ST_RUN || state == ST_WAIT) ? rd_data : '0;

endmodule

// File: tb/tb_dot_feeder_14.sv
// Bench for dot_feeder_14. It contains:
//   - a behavioural dot channel;
//   - a transaction-level reference model;
//   - one compare process that runs on every negedge.
// With DOT_FEEDER_TIMEOUT_EN defined, the watchdog is exercised as well.
module tb_dot_feeder_14;
  import dot_feeder_14_pkg::*;

  localparam int NPH = 6;
  localparam int WSL = 1;
  localparam int TOC = 20;
  localparam int DL  = DATA_LEN;
  localparam int NE  = N_ELEM;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [3:0]          in_cs = '0;
  logic [VEC_W-1:0]    in_data = '0;
  logic                dc_load, ws_load;
  logic [3:0]          cs;
  logic [PH_W-1:0]     phase;
  logic [VEC_W-1:0]    d;
  logic                dc_valid = 1'b0;
  logic [DL-1:0]       dc_q = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [3:0]          res_cs;
  logic [DL-1:0]       res_data;
  logic                err;

  always #5 clk = ~clk;

  dot_feeder_14 #(.N_PHASE(NPH), .WS_LAT(WSL), .TO_CYC(TOC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cs(in_cs),
    .in_data(in_data), .dc_load(dc_load), .ws_load(ws_load), .cs(cs), .phase(phase),
    .d(d), .dc_valid(dc_valid), .dc_q(dc_q), .res_valid(res_valid), .res_ready(res_ready),
    .res_cs(res_cs), .res_data(res_data), .err(err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Channel weight store; changed only between transactions.
  int wt [NPH][NE];

  // Reference model state.
  //   m_mode: 0 = taking slices, 1 = computing, 2 = result offered.
  //   m_run:  cycles since the compute window opened.
  int               m_mode  = 0;
  int               m_beats = 0;
  int               m_run   = 0;
  logic [VEC_W-1:0] m_slc [NPH];
  logic [3:0]       m_cs    = '0;
  logic [DL-1:0]    m_q     = '0;
  logic             m_err   = 1'b0;
  bit               chk_en  = 1'b0;
  bit               ch_mute = 1'b0;

  // Channel model state.
  int ch_k = 0, ch_acc = 0, ch_fire_at = 0;
  bit ch_fired = 1'b0;
  int ch_ph [32];

  function automatic logic [DL-1:0] ref_dot();
    int s = 0;
    for (int k = 0; k < NPH; k++)
      for (int e = 0; e < NE; e++)
        s += int'(m_slc[k][e*DL +: DL]) * wt[k][e];
    return DL'(s);
  endfunction

  always @(negedge clk) begin
    int idx;
    int ph_exp;
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_mode == 0 && !rst));
      chk("dc_load", 64'(dc_load), 64'(m_mode == 1));
      chk("ws_load", 64'(ws_load), 64'(m_mode == 1));
      chk("res_valid", 64'(res_valid), 64'(m_mode == 2));
      chk("err", 64'(err), 64'(m_err));
      if (m_mode == 1) begin
        ph_exp = (m_run < NPH - 1) ? m_run : NPH - 1;
        idx = m_run - WSL;
        if (idx < 0) idx = 0;
        if (idx > NPH - 1) idx = NPH - 1;
        chk("phase", 64'(phase), 64'(ph_exp));
        chk("cs", 64'(cs), 64'(m_cs));
        chk_v("d", d, m_slc[idx]);
      end
      if (m_mode == 2) begin
        chk("res_data", 64'(res_data), 64'(m_q));
        chk("res_cs", 64'(res_cs), 64'(m_cs));
      end
    end

    // Behavioural channel: weights reach the channel WSL cycles after the
    // phase. It accumulates NPH aligned phases and answers 2..4 cycles later.
    dc_valid = 1'b0;
    if (!dc_load) begin
      ch_k = 0; ch_acc = 0; ch_fired = 1'b0;
      ch_fire_at = NPH + WSL - 1 + int'($urandom_range(2, 4));
      if (m_mode != 1 && $urandom_range(0, 3) == 0) begin
        dc_valid = 1'b1;
        dc_q = DL'($urandom);
      end
    end else begin
      if (ch_k < 32) ch_ph[ch_k] = int'(phase);
      if (ch_k >= WSL && ch_k < WSL + NPH)
        for (int e = 0; e < NE; e++)
          ch_acc += int'(d[e*DL +: DL]) * wt[ch_ph[ch_k - WSL]][e];
      if (!ch_fired && !ch_mute && ch_k == ch_fire_at) begin
        dc_valid = 1'b1;
        dc_q = DL'(ch_acc);
        ch_fired = 1'b1;
      end
      ch_k++;
    end

    // Advance the reference model across the coming edge.
    if (rst) begin
      m_mode = 0; m_beats = 0; m_err = 1'b0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
             m_slc[m_beats] = in_data;
             if (m_beats == 0) m_cs = in_cs;
             m_beats++;
             if (m_beats == NPH) begin
               m_mode = 1; m_run = 0; m_q = ref_dot();
             end
           end
        1: begin
             if (dc_valid && m_run >= NPH + WSL) m_mode = 2;
`ifdef DOT_FEEDER_TIMEOUT_EN
             else if (m_run >= NPH + WSL && m_run == TOC - 1) begin
               m_mode = 2; m_q = '0; m_err = 1'b1;
             end
`endif
             else m_run++;
           end
        2: if (res_ready) begin m_mode = 0; m_beats = 0; end
        default: m_mode = 0;
      endcase
    end
  end

  function automatic logic [VEC_W-1:0] mk_slice(input int kind, input int k);
    logic [VEC_W-1:0] s;
    int v;
    s = '0;
    for (int e = 0; e < NE; e++) begin
      if (kind == 0)      v = k + 1;
      else if (kind == 2) v = (k * NE + e) % 251;
      else                v = int'($urandom_range(0, 63));
      s[e*DL +: DL] = DL'(v);
    end
    return s;
  endfunction

  task automatic set_wt(input bit ones);
    for (int k = 0; k < NPH; k++)
      for (int e = 0; e < NE; e++)
        wt[k][e] = ones ? 1 : int'($urandom_range(0, 7));
  endtask

  // gmode: 0 = back-to-back beats, 1 = alternating gaps, 2 = random gaps.
  task automatic send(input logic [3:0] c, input int kind, input int gmode);
    int k = 0;
    int g = 0;
    bit gap;
    while (k < NPH) begin
      gap = (gmode == 1) ? g[0] : ((gmode == 2) ? ($urandom_range(0, 99) < 40) : 1'b0);
      g++;
      if (gap) begin
        in_valid = 1'b0;
        in_data  = '0;
      end else begin
        in_valid = 1'b1;
        in_cs    = (k == 0) ? c : 4'($urandom);
        in_data  = mk_slice(kind, k);
        k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_res(input int budget);
    int t = 0;
    while (!res_valid && t < budget) begin @(posedge clk); #1; t++; end
    chk("res_valid_arrives", 64'(res_valid), 64'd1);
  endtask

  // bp < 0 means random backpressure; otherwise res_ready stays low for bp cycles.
  task automatic drain(input int bp);
    int t = 0;
    if (bp < 0) begin
      while (res_valid && t < 50) begin
        res_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1; t++;
      end
    end else begin
      res_ready = 1'b0;
      repeat (bp) begin @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    chk("idle_after_handshake", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int t;
    set_wt(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_dc_load", 64'(dc_load), 64'd0);
    chk("rst_ws_load", 64'(ws_load), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_cs", 64'(cs), 64'd0);
    chk("rst_res_cs", 64'(res_cs), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_v("rst_d", d, '0);
    chk_en = 1'b1;

    // Basic transaction: 36 elements times (1+2+...+6) = 756.
    send(4'd3, 0, 0);
    chk("run_start_basic", 64'(dc_load), 64'd1);
    wait_res(40);
    chk("basic_res_data", 64'(res_data), 64'd756);
    chk("basic_res_cs", 64'(res_cs), 64'd3);
    drain(0);

    // Upstream gaps give the same result. RUN starts one cycle after the last accept.
    send(4'd3, 0, 1);
    chk("run_start_gaps", 64'(dc_load), 64'd1);
    wait_res(40);
    chk("gaps_res_data", 64'(res_data), 64'd756);
    drain(0);

    // Result held under 10 cycles of backpressure.
    set_wt(1'b0);
    send(4'd9, 2, 0);
    wait_res(40);
    drain(10);

    // Reset while phase 3 is on the channel.
    send(4'd5, 1, 0);
    t = 0;
    while (phase != 3'd3 && t < 20) begin @(posedge clk); #1; t++; end
    chk("phase3_reached", 64'(phase), 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_dc_load", 64'(dc_load), 64'd0);
    chk("midrst_ws_load", 64'(ws_load), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    send(4'd6, 1, 0);
    wait_res(40);
    drain(-1);

`ifdef DOT_FEEDER_TIMEOUT_EN
    ch_mute = 1'b1;
    send(4'd2, 1, 0);
    wait_res(TOC + 10);
    chk("to_err", 64'(err), 64'd1);
    chk("to_res_data", 64'(res_data), 64'd0);
    drain(2);
    chk("to_err_sticky", 64'(err), 64'd1);
    ch_mute = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("to_err_cleared", 64'(err), 64'd0);
`endif

    // Randomized transactions.
    for (int n = 0; n < 25; n++) begin
      set_wt(1'b0);
      send(4'($urandom), 1, 2);
      wait_res(40);
      drain((n % 3 == 0) ? int'($urandom_range(0, 4)) : -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
